// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage registers.
// Holds the skid-buffer state encoding and the default ID/EX payload layout.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        TWO   = ST_TWO
    } pipe_state_t;

    // ID/EX payload: pc | rs1 | rs2 | imm | rd | control, LSB first.
    localparam int unsigned ID_EX_W        = 155;
    localparam int unsigned ID_EX_PC_LSB   = 0;
    localparam int unsigned ID_EX_RS1_LSB  = 32;
    localparam int unsigned ID_EX_RS2_LSB  = 64;
    localparam int unsigned ID_EX_IMM_LSB  = 96;
    localparam int unsigned ID_EX_RD_LSB   = 128;
    localparam int unsigned ID_EX_CTRL_LSB = 133;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc)
            count <= sat_inc(count);
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a two-entry skid buffer and registered in_ready.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = ID_EX_W,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_skid_reg: DATA_W and CNT_W must be at least 1");
    end

    pipe_state_t       state, state_next;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              load_main, main_from_skid, load_skid, clear_data;

    // Both handshake outputs come straight from the state flops.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != TWO);
    assign out_data  = main_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        clear_data     = 1'b0;
        if (flush) begin
            state_next = EMPTY;
            clear_data = CLEAR_ON_FLUSH;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        load_main  = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        load_main = 1'b1;
                    end else if (in_valid) begin
                        load_skid  = 1'b1;
                        state_next = TWO;
                    end else if (out_ready) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= '0;
            skid_data <= '0;
        end else if (clear_data) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_main)
                main_data <= main_from_skid ? skid_data : in_data;
            if (load_skid)
                skid_data <= in_data;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, corner sequences, and a
// queue-based reference model under random traffic. Honours PIPE_PERF_CNT_EN.
module tb_pipe_skid_reg;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;

    logic         k_flush = 1'b0, k_in_valid = 1'b0, k_out_ready = 1'b0;
    logic [W-1:0] k_in_data = '0;
    logic         k_in_ready, k_out_valid;
    logic [W-1:0] k_out_data;

`ifdef PIPE_PERF_CNT_EN
    logic [1:0] stall_cnt, flush_cnt;
    logic [1:0] k_stall_cnt, k_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    pipe_skid_reg #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b0), .CNT_W(2)) u_keep (
        .clk       (clk),
        .rst       (rst),
        .flush     (k_flush),
        .in_valid  (k_in_valid),
        .in_ready  (k_in_ready),
        .in_data   (k_in_data),
        .out_valid (k_out_valid),
        .out_ready (k_out_ready),
        .out_data  (k_out_data)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (k_stall_cnt),
        .flush_cnt (k_flush_cnt)
`endif
    );

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         eov;
        logic [W-1:0] eod;
        logic         eir;
    } vec_t;

    vec_t vecs[13];

    // Reference model: an ordered list of held beats plus the last shown payload.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step();
        step();
        rst = 1'b0;
        mq.delete();
        m_out = '0;
    endtask

    initial begin
        // Stream 1..4, then idle.
        vecs[0]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1};
        vecs[1]  = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1};
        vecs[2]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b1};
        vecs[3]  = '{1'b1, 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b1};
        // Stall into the skid, drain, 0xC refused while full.
        vecs[5]  = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1};
        vecs[6]  = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0};
        vecs[7]  = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 16'h000B, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h000B, 1'b1};
        // Fill both entries, flush with an incoming beat.
        vecs[9]  = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1};
        vecs[10] = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0};
        vecs[11] = '{1'b1, 16'h000C, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};

        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_data", {16'b0, out_data}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
`ifdef PIPE_PERF_CNT_EN
        chk("reset stall_cnt", {30'b0, stall_cnt}, 32'd0);
        chk("reset flush_cnt", {30'b0, flush_cnt}, 32'd0);
`endif
        do_reset();

        for (int i = 0; i < 13; i++) begin
            in_valid = vecs[i].iv; in_data = vecs[i].d;
            out_ready = vecs[i].ordy; flush = vecs[i].fl;
            step();
            chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eov});
            chk($sformatf("vec%0d out_data", i), {16'b0, out_data}, {16'b0, vecs[i].eod});
            chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].eir});
        end
        flush = 1'b0; in_valid = 1'b0;

        // Async reset in the middle of a stalled cycle.
        in_valid = 1'b1; in_data = 16'h00AA; out_ready = 1'b0;
        step();
        in_data = 16'h00BB;
        step();
        in_valid = 1'b0;
        chk("pre-rst in_ready", {31'b0, in_ready}, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("async rst out_data", {16'b0, out_data}, 32'd0);
        chk("async rst in_ready", {31'b0, in_ready}, 32'd1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("post rst in_ready", {31'b0, in_ready}, 32'd1);

        // Flush without payload clearing.
        k_in_valid = 1'b1; k_in_data = 16'h0005; k_out_ready = 1'b0;
        step();
        k_in_valid = 1'b0;
        chk("keep load out_valid", {31'b0, k_out_valid}, 32'd1);
        chk("keep load out_data", {16'b0, k_out_data}, 32'd5);
        k_flush = 1'b1;
        step();
        k_flush = 1'b0;
        chk("keep flush out_valid", {31'b0, k_out_valid}, 32'd0);
        chk("keep flush out_data", {16'b0, k_out_data}, 32'd5);
        chk("keep flush in_ready", {31'b0, k_in_ready}, 32'd1);

`ifdef PIPE_PERF_CNT_EN
        do_reset();
        chk("cnt reset stall", {30'b0, stall_cnt}, 32'd0);
        in_valid = 1'b1; in_data = 16'h0007; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("stall_cnt saturated", {30'b0, stall_cnt}, 32'd3);
        chk("flush_cnt before", {30'b0, flush_cnt}, 32'd0);
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        chk("flush_cnt two", {30'b0, flush_cnt}, 32'd2);
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic m_ir, m_ov;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = W'($urandom);
            m_ir = (mq.size() < 2);
            m_ov = (mq.size() > 0);
            step();
            if (flush) begin
                mq.delete();
                m_out = '0;
            end else begin
                if (m_ov && out_ready) void'(mq.pop_front());
                if (in_valid && m_ir) mq.push_back(in_data);
                if (mq.size() > 0) m_out = mq[0];
            end
            chk($sformatf("rnd%0d out_valid", c), {31'b0, out_valid}, {31'b0, (mq.size() > 0)});
            chk($sformatf("rnd%0d in_ready", c), {31'b0, in_ready}, {31'b0, (mq.size() < 2)});
            chk($sformatf("rnd%0d out_data", c), {16'b0, out_data}, {16'b0, m_out});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised elastic pipeline-stage register; successor to the fixed ID/EX latch.
- Carries an opaque DATA_W-bit payload (packed control + operands) between stages with a valid/ready handshake.
- Two-entry skid buffer keeps in_ready registered, so stall timing stays clean. Synchronous flush inserts bubbles.
- Instantiated at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 155, payload width in bits (≥1).
- CLEAR_ON_FLUSH, 1, 1 = zero the payload registers on flush; 0 = keep payload contents, clear only the valid bits.
- CNT_W, 16, performance counter width; used only with PIPE_PERF_CNT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous bubble insert; kills all held and incoming beats.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts; low = stall.
- out_data  out  DATA_W  payload of the main entry.
- stall_cnt  out  CNT_W  PIPE_PERF_CNT_EN only.
- flush_cnt  out  CNT_W  PIPE_PERF_CNT_EN only.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, skid entry and its valid=0, in_ready=1, state EMPTY, counters=0.
- Storage: main entry drives out_data/out_valid; skid entry is internal.
- Latency: 1 cycle in_data→out_data when not stalled. Full throughput of 1 beat/cycle.
- Transfers occur only when valid&ready are both high at the rising edge.
- States and per-cycle transitions (flush=0):
  - EMPTY (out_valid=0, in_ready=1): in_valid → main<=in_data, go to ONE; otherwise stay.
  - ONE (out_valid=1, in_ready=1):
    - in_valid&out_ready → main<=in_data, stay ONE.
    - in_valid&!out_ready → skid<=in_data, go to TWO.
    - !in_valid&out_ready → go to EMPTY.
    - Otherwise hold.
  - TWO (out_valid=1, in_ready=0): out_ready → main<=skid, go to ONE; otherwise hold both entries.
- in_ready = !skid_valid (registered). It is never combinationally dependent on out_ready.
- out_data is stable while out_valid&!out_ready. Payload is never reordered, duplicated or lost absent flush.
- Flush has priority over every transfer:
  - Next state is EMPTY; main and skid valid bits clear.
  - A beat presented with in_valid&in_ready in the flush cycle counts as accepted and is discarded.
  - A beat output in the flush cycle with out_ready=1 is consumed downstream normally; the flush affects the next state only.
  - CLEAR_ON_FLUSH=1: main and skid payload <=0 (out_data=0 the next cycle). CLEAR_ON_FLUSH=0: payload held, out_valid=0.
- Reset asserted mid-stall (TWO): both entries are lost immediately. After release: EMPTY, in_ready=1.
- In EMPTY, out_data keeps its last value unless cleared by flush or reset. Consumers qualify it with out_valid.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each cycle with out_valid&!out_ready.
  - flush_cnt increments on each flush cycle.
  - Both saturate at 2^CNT_W-1 and reset to 0 on rst.
- Undefined: the counter ports and logic are absent; functional behaviour is identical.

Decomposition:
- pipe_pkg holds:
  - pipe_state_t enum {EMPTY, ONE, TWO} (2 bits);
  - ST_EMPTY/ST_ONE/ST_TWO encodings;
  - the default ID/EX payload width constant ID_EX_W=155 and its field offset constants.
- One sub-module, pipe_sat_counter (CNT_W, inc, saturating, async reset), instantiated twice under PIPE_PERF_CNT_EN.

Test Plan:
1. Reset, then stream in_data=1,2,3,4 on consecutive cycles with out_ready=1 → out_data 1,2,3,4 one cycle later each; in_ready stays 1.
2. ONE holding 0xA, out_ready=0, push 0xB → TWO, in_ready=0 next cycle. Raise out_ready → out 0xA, then 0xB; 0xC offered while in_ready=0 is not taken.
3. In TWO (0xA, 0xB), flush=1 with in_valid=1, in_data=0xC → next cycle out_valid=0, in_ready=1, out_data=0 (CLEAR_ON_FLUSH=1); 0xC never appears.
4. CLEAR_ON_FLUSH=0, main=0x5 valid, flush → out_valid=0, out_data remains 0x5.
5. Assert rst asynchronously mid-cycle in TWO → out_valid=0, out_data=0, in_ready=1 without waiting for a clock edge.
6. PIPE_PERF_CNT_EN, CNT_W=2: hold out_valid=1 and out_ready=0 for 5 cycles → stall_cnt=3 (saturated). 2 flushes → flush_cnt=2.
